// File: rtl/prll_bs_pkg.sv
// Shared types and helpers for the parallel bus round-robin arbiter/router.
package prll_bs_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  localparam int MAX_W = 256;

  // All-ones pattern; the top slices it down to id_w for the default broadcast ID.
  localparam logic [MAX_W-1:0] BCAST_DEF = '1;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [MAX_W-1:0] onehot(input int unsigned idx, input int unsigned n);
    return (idx < n) ? (MAX_W'(1) << idx) : '0;
  endfunction

endpackage

// File: rtl/prll_bs_rr_arb.sv
// Combinational round-robin search: first set request after 'last', with wrap-around.
module prll_bs_rr_arb
  import prll_bs_pkg::*;
#(
  parameter  int n  = 9,
  localparam int IW = idx_w(n)
) (
  input  logic [n-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_vld
);

  logic [IW-1:0] cand;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 1; k <= n; k++) begin
      cand = IW'((int'(last) + k) % n);
      if (!gnt_vld && req[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

endmodule

// File: rtl/prll_bs_rbtr_nd.sv
// Shared-bus arbiter/router: pops one packet round-robin, then pushes it to its
// destination driver or broadcasts it atomically. Optional drop counter: PRLL_BS_DROP_CNT_EN.
module prll_bs_rbtr_nd
  import prll_bs_pkg::*;
#(
  parameter int               bits      = 256,
  parameter int               drvrs     = 9,
  parameter int               id_w      = 8,
  parameter logic [id_w-1:0]  broadcast = BCAST_DEF[id_w-1:0]
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [drvrs-1:0]       pndng,
  input  logic [drvrs-1:0]       full,
  input  logic [drvrs*bits-1:0]  D_pop,
  output logic [drvrs-1:0]       pop,
  output logic [drvrs-1:0]       push,
  output logic [bits-1:0]        D_push,
  output logic                   busy
`ifdef PRLL_BS_DROP_CNT_EN
  ,
  output logic [15:0]            drop_cnt
`endif
);

  localparam int IW = idx_w(drvrs);
  localparam int CW = ((id_w > 31) ? id_w : 31) + 1;

  state_e           state_q, state_d;
  logic [bits-1:0]  pkt_q, pkt_d, d_push_q, d_push_d;
  logic [IW-1:0]    src_q, src_d, rr_last_q, rr_last_d;
  logic [drvrs-1:0] pop_q, pop_d, push_q, push_d, tgt;
  logic [IW-1:0]    gnt_idx;
  logic             gnt_vld;
  logic [id_w-1:0]  dest;
  logic             is_bcast, dest_ok, send_ok;
  logic [bits-1:0]  heads [drvrs];

  for (genvar g = 0; g < drvrs; g++) begin : g_heads
    assign heads[g] = D_pop[g*bits +: bits];
  end

  prll_bs_rr_arb #(.n(drvrs)) u_arb (
    .req     (pndng),
    .last    (rr_last_q),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  // Destination decode of the held packet; broadcast takes precedence over a plain ID.
  assign dest     = pkt_q[bits-1 -: id_w];
  assign is_bcast = (dest == broadcast);
  assign dest_ok  = (CW'(dest) < CW'(drvrs));

  always_comb begin
    tgt = '0;
    if (is_bcast)     tgt = ~drvrs'(onehot(int'(src_q), drvrs));
    else if (dest_ok) tgt = drvrs'(onehot(int'(dest), drvrs));
  end

  // An invalid destination yields tgt=0, which always "sends" and so drops the packet.
  assign send_ok = ((tgt & full) == '0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_vld) state_d = SEND;
      SEND:    if (send_ok) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pkt_d     = pkt_q;
    src_d     = src_q;
    rr_last_d = rr_last_q;
    d_push_d  = d_push_q;
    pop_d     = '0;
    push_d    = '0;
    if (state_q == IDLE && gnt_vld) begin
      pkt_d     = heads[gnt_idx];
      src_d     = gnt_idx;
      rr_last_d = gnt_idx;
      pop_d     = drvrs'(onehot(int'(gnt_idx), drvrs));
    end else if (state_q == SEND && send_ok) begin
      push_d = tgt;
      if (tgt != '0) d_push_d = pkt_q;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q   <= IDLE;
      pkt_q     <= '0;
      src_q     <= '0;
      rr_last_q <= IW'(drvrs - 1);
      d_push_q  <= '0;
      pop_q     <= '0;
      push_q    <= '0;
    end else begin
      state_q   <= state_d;
      pkt_q     <= pkt_d;
      src_q     <= src_d;
      rr_last_q <= rr_last_d;
      d_push_q  <= d_push_d;
      pop_q     <= pop_d;
      push_q    <= push_d;
    end
  end

  assign pop    = pop_q;
  assign push   = push_q;
  assign D_push = d_push_q;
  assign busy   = (state_q == SEND);

`ifdef PRLL_BS_DROP_CNT_EN
  logic        drop;
  logic [15:0] drop_cnt_q;

  assign drop = (state_q == SEND) && !is_bcast && !dest_ok;

  always_ff @(posedge clk) begin
    if (reset)                             drop_cnt_q <= '0;
    else if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule
